// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter and its helpers.
package dmem_arb_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WRITE  = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  localparam logic OWN_M0 = 1'b0;
  localparam logic OWN_M1 = 1'b1;

  localparam int DEF_ADDR_W = 11;
  localparam int DEF_DATA_W = 32;
endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and memory-port bundle for dmem_arbiter; slave = arbiter side.
interface dmem_arbiter_if import dmem_arb_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  localparam int BE_W = DATA_W / 8;

  logic              m0_req,   m1_req;
  logic              m0_we,    m1_we;
  logic [BE_W-1:0]   m0_be,    m1_be;
  logic [ADDR_W-1:0] m0_addr,  m1_addr;
  logic [DATA_W-1:0] m0_wdata, m1_wdata;
  logic              m0_ack,   m1_ack;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  m0_req, m0_we, m0_be, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_be, m1_addr, m1_wdata,
    output m0_ack, m0_rdata, m1_ack, m1_rdata,
    output mem_addr, mem_wdata, mem_we, busy,
    input  mem_rdata
  );

  modport master (
    output m0_req, m0_we, m0_be, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_be, m1_addr, m1_wdata,
    input  m0_ack, m0_rdata, m1_ack, m1_rdata,
    input  mem_addr, mem_wdata, mem_we, busy,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_be_merge.sv
// Byte-lane merge: each lane takes new_word where be is set, else old_word.
module dmem_be_merge import dmem_arb_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0]   old_word,
  input  logic [DATA_W-1:0]   new_word,
  input  logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   merged
);
  for (genvar i = 0; i < DATA_W/8; i++) begin : g_lane
    assign merged[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
  end
endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory; fixed priority to m0 with a
// starvation guard for m1, and read-modify-write for sub-word stores.
module dmem_arbiter import dmem_arb_pkg::*; #(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = 4
) (
  input logic           clk,
  input logic           rst_n,
  dmem_arbiter_if.slave bus
);
  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  state_e            state, state_nxt;
  logic              owner;
  logic              we_q;
  logic [BE_W-1:0]   be_q;
  logic [CNT_W-1:0]  starve_cnt;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] m0_rdata_q, m1_rdata_q;
  logic              m0_ack_q, m1_ack_q;
  logic              grant_m0, grant_m1, starved;
  logic              be_full, be_none, partial, mem_we_dec;
  logic [DATA_W-1:0] merged, cap_data;

  assign starved = (starve_cnt == CNT_W'(STARVE_LIMIT));
  assign be_full = &be_q;
  assign be_none = ~|be_q;
  assign partial = we_q && !be_full && !be_none;

  // While latched in ACCESS, mem_wdata_q still holds the requester's write data.
  dmem_be_merge #(.DATA_W(DATA_W)) u_merge (
    .old_word (bus.mem_rdata),
    .new_word (mem_wdata_q),
    .be       (be_q),
    .merged   (merged)
  );

  always_comb begin
    state_nxt  = state;
    grant_m0   = 1'b0;
    grant_m1   = 1'b0;
    mem_we_dec = 1'b0;
    cap_data   = bus.mem_rdata;
    case (state)
      ST_IDLE: begin
        if (bus.m1_req && (!bus.m0_req || starved)) grant_m1 = 1'b1;
        else if (bus.m0_req)                        grant_m0 = 1'b1;
        if (grant_m0 || grant_m1) state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        mem_we_dec = we_q && be_full;
        if (we_q && !be_none) cap_data = be_full ? mem_wdata_q : merged;
        state_nxt = partial ? ST_WRITE : ST_RESP;
      end
      ST_WRITE: begin
        mem_we_dec = 1'b1;
        state_nxt  = ST_RESP;
      end
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      owner       <= OWN_M0;
      we_q        <= 1'b0;
      be_q        <= '0;
      starve_cnt  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
      m0_ack_q    <= 1'b0;
      m1_ack_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      m0_ack_q <= 1'b0;
      m1_ack_q <= 1'b0;
      if (state == ST_IDLE) begin
        if (grant_m1 || !bus.m1_req)     starve_cnt <= '0;
        else if (grant_m0 && !starved)   starve_cnt <= starve_cnt + 1'b1;
        if (grant_m0 || grant_m1) begin
          owner       <= grant_m1 ? OWN_M1 : OWN_M0;
          we_q        <= grant_m1 ? bus.m1_we    : bus.m0_we;
          be_q        <= grant_m1 ? bus.m1_be    : bus.m0_be;
          mem_addr_q  <= grant_m1 ? bus.m1_addr  : bus.m0_addr;
          mem_wdata_q <= grant_m1 ? bus.m1_wdata : bus.m0_wdata;
        end
      end
      if (state == ST_ACCESS) begin
        if (owner == OWN_M1) m1_rdata_q <= cap_data;
        else                 m0_rdata_q <= cap_data;
        if (partial) mem_wdata_q <= merged;
      end
      if (state_nxt == ST_RESP) begin
        m0_ack_q <= (owner == OWN_M0);
        m1_ack_q <= (owner == OWN_M1);
      end
    end
  end

  // Reset gates the write strobe combinationally so an interrupted store never commits.
  assign bus.mem_we    = rst_n ? mem_we_dec : 1'b0;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.m0_ack    = m0_ack_q;
  assign bus.m1_ack    = m1_ack_q;
  assign bus.m0_rdata  = m0_rdata_q;
  assign bus.m1_rdata  = m1_rdata_q;
  assign bus.busy      = (state != ST_IDLE);
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural 2048x32 memory.
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(11), .DATA_W(32)) bus ();

  dmem_arbiter #(.ADDR_W(11), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0, n_fail = 0, we_cnt = 0, ack_cnt = 0;
  logic [31:0] q0[$], q1[$];
  bit          ord[$];
  bit          log_en = 1'b0;
  logic [31:0] mem [2048];
  logic        pl_en = 1'b0;
  logic [10:0] pl_addr = '0;
  logic [31:0] pl_data = '0;

  assign bus.mem_rdata = mem[bus.mem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // memory: commits on the falling edge; preload port shares the same process
  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = '0;
    forever begin
      @(negedge clk);
      if (pl_en)            mem[pl_addr] = pl_data;
      else if (bus.mem_we)  mem[bus.mem_addr] = bus.mem_wdata;
    end
  end

  // monitor: pops the scoreboard on every ack
  always @(negedge clk) begin
    chk("ack_excl", {31'd0, bus.m0_ack & bus.m1_ack}, 32'd0);
    if (bus.mem_we) we_cnt++;
    if (bus.m0_ack) begin
      ack_cnt++;
      if (log_en) ord.push_back(1'b0);
      chk("m0_pending", 32'(q0.size() > 0), 32'd1);
      if (q0.size() > 0) chk("m0_rdata", bus.m0_rdata, q0.pop_front());
    end
    if (bus.m1_ack) begin
      ack_cnt++;
      if (log_en) ord.push_back(1'b1);
      chk("m1_pending", 32'(q1.size() > 0), 32'd1);
      if (q1.size() > 0) chk("m1_rdata", bus.m1_rdata, q1.pop_front());
    end
  end

  task automatic drive(input bit p, input logic rq, input logic we, input logic [3:0] be,
                       input logic [10:0] a, input logic [31:0] d);
    if (p) begin
      bus.m1_req = rq; bus.m1_we = we; bus.m1_be = be; bus.m1_addr = a; bus.m1_wdata = d;
    end else begin
      bus.m0_req = rq; bus.m0_we = we; bus.m0_be = be; bus.m0_addr = a; bus.m0_wdata = d;
    end
  endtask

  task automatic preload(input logic [10:0] a, input logic [31:0] d);
    pl_addr = a; pl_data = d; pl_en = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // counts rising edges from req assertion to the first ack seen
  task automatic wait_ack(input bit p, output int n);
    n = -1;
    for (int i = 1; i <= 20 && n < 0; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (p ? bus.m1_ack : bus.m0_ack) n = i;
    end
  endtask

  task automatic do_req(input bit p, input logic we, input logic [3:0] be, input logic [10:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rd, input int exp_lat,
                        input string tag);
    int n;
    drive(p, 1'b1, we, be, a, d);
    if (p) q1.push_back(exp_rd);
    else   q0.push_back(exp_rd);
    wait_ack(p, n);
    chk({tag, "_lat"}, n, exp_lat);
    @(posedge clk); #1;
    drive(p, 1'b0, 1'b0, 4'h0, 11'h0, 32'h0);
  endtask

  initial begin
    int n, a0, w0;
    drive(1'b0, 1'b0, 1'b0, 4'h0, 11'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 4'h0, 11'h0, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m0_ack",    bus.m0_ack,    32'd0);
    chk("rst_m1_ack",    bus.m1_ack,    32'd0);
    chk("rst_busy",      bus.busy,      32'd0);
    chk("rst_mem_we",    bus.mem_we,    32'd0);
    chk("rst_mem_addr",  bus.mem_addr,  32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_m0_rdata",  bus.m0_rdata,  32'd0);
    chk("rst_m1_rdata",  bus.m1_rdata,  32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // full write then read back
    do_req(1'b0, 1'b1, 4'hF, 11'h005, 32'hDEADBEEF, 32'hDEADBEEF, 2, "wr_full");
    do_req(1'b0, 1'b0, 4'h0, 11'h005, 32'h0,        32'hDEADBEEF, 2, "rd_005");
    chk("we_cnt_full", we_cnt, 32'd1);
    chk("mem_005", mem[11'h005], 32'hDEADBEEF);

    // partial store through read-modify-write
    preload(11'h010, 32'h11223344);
    w0 = we_cnt;
    do_req(1'b1, 1'b1, 4'h2, 11'h010, 32'h0000AA00, 32'h1122AA44, 3, "wr_part");
    chk("mem_010", mem[11'h010], 32'h1122AA44);
    chk("we_cnt_part", we_cnt, w0 + 1);

    // be == 0 behaves as a read
    preload(11'h020, 32'h12345678);
    w0 = we_cnt;
    do_req(1'b0, 1'b1, 4'h0, 11'h020, 32'hFFFFFFFF, 32'h12345678, 2, "wr_be0");
    chk("we_cnt_be0", we_cnt, w0);
    chk("mem_020", mem[11'h020], 32'h12345678);

    // reset in the WRITE cycle of a partial store
    preload(11'h030, 32'hAABBCCDD);
    a0 = ack_cnt; w0 = we_cnt;
    drive(1'b0, 1'b1, 1'b1, 4'h1, 11'h030, 32'h000000EE);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 4'h0, 11'h0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("rstw_mem_030",   mem[11'h030],  32'hAABBCCDD);
    chk("rstw_no_ack",    ack_cnt,       a0);
    chk("rstw_no_we",     we_cnt,        w0);
    chk("rstw_busy",      bus.busy,      32'd0);
    chk("rstw_m0_rdata",  bus.m0_rdata,  32'd0);
    chk("rstw_mem_addr",  bus.mem_addr,  32'd0);
    chk("rstw_mem_wdata", bus.mem_wdata, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_req(1'b1, 1'b0, 4'h0, 11'h030, 32'h0, 32'hAABBCCDD, 2, "post_rst_rd");

    // req held across ack with a new address
    a0 = ack_cnt;
    drive(1'b0, 1'b1, 1'b0, 4'h0, 11'h005, 32'h0);
    q0.push_back(32'hDEADBEEF);
    q0.push_back(32'h1122AA44);
    wait_ack(1'b0, n);
    chk("hold1_lat", n, 32'd2);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 4'h0, 11'h010, 32'h0);
    wait_ack(1'b0, n);
    chk("hold2_lat", n, 32'd2);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 4'h0, 11'h0, 32'h0);
    repeat (4) @(posedge clk);
    #1;
    chk("hold_acks", ack_cnt, a0 + 2);

    // both requesting continuously: m0 x4 then m1
    preload(11'h040, 32'h0A0A0A0A);
    preload(11'h041, 32'h1B1B1B1B);
    ord.delete();
    log_en = 1'b1;
    a0 = ack_cnt;
    repeat (8) q0.push_back(32'h0A0A0A0A);
    repeat (2) q1.push_back(32'h1B1B1B1B);
    drive(1'b0, 1'b1, 1'b0, 4'h0, 11'h040, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 4'h0, 11'h041, 32'h0);
    for (int i = 0; i < 100 && ack_cnt < a0 + 10; i++) begin
      @(negedge clk); #1;
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 4'h0, 11'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 4'h0, 11'h0, 32'h0);
    repeat (4) @(posedge clk);
    #1;
    log_en = 1'b0;
    chk("starve_total", ack_cnt, a0 + 10);
    chk("starve_len", ord.size(), 32'd10);
    for (int i = 0; i < ord.size(); i++) chk("starve_ord", ord[i], 32'(i % 5 == 4));

    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester access controller for the 2048×32 word-addressed data memory. It arbitrates between the CPU data port (m0) and a loader/debug port (m1) using fixed priority with a starvation guard. It sequences each access onto the single memory port. Sub-word stores are turned into read-modify-write cycles, because the memory itself only performs full-word writes.

## Interface
Parameters:
- ADDR_W, 11, word-address width (2048 words)
- DATA_W, 32, data width; byte-enable width BE_W = DATA_W/8
- STARVE_LIMIT, 4, consecutive m0 grants allowed while m1 is pending

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- m0_req, m1_req  in  1  request; held with fields stable until ack
- m0_we, m1_we  in  1  1 = write, 0 = read
- m0_be, m1_be  in  BE_W  byte enables for writes; bit i covers byte i
- m0_addr, m1_addr  in  ADDR_W  word address
- m0_wdata, m1_wdata  in  DATA_W  write data
- m0_ack, m1_ack  out  1  one-cycle completion pulse
- m0_rdata, m1_rdata  out  DATA_W  word read at the access address; valid while ack is high, held otherwise
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_we  out  1  memory write enable; the memory commits on the falling edge inside the cycle
- mem_rdata  in  DATA_W  combinational memory read data
- busy  out  1  high whenever the state is not IDLE

## Operation
States: IDLE, ACCESS, WRITE, RESP.

- **IDLE**
  - Samples both req lines.
  - On a grant, latches owner, we, be, addr and wdata, then goes to ACCESS.
  - If no req is high, stays in IDLE.
- **Arbitration**
  - m0 wins when both are requesting, unless starve_cnt == STARVE_LIMIT; then m1 wins.
  - starve_cnt increments on each m0 grant while m1_req is high, saturating at the limit.
  - starve_cnt clears on an m1 grant, or in any IDLE cycle with m1_req low.
- **ACCESS**
  - mem_addr is the latched address.
  - Read: capture mem_rdata into the owner's rdata register, go to RESP.
  - Write with be == all-ones: mem_we = 1 and mem_wdata = latched wdata, go to RESP.
  - Write with be == 0: no-op. No mem_we; capture mem_rdata as for a read; go to RESP.
  - Write with a partial be: no mem_we. Merge register = per byte, be[i] ? wdata byte : mem_rdata byte. Go to WRITE.
- **WRITE**
  - mem_we = 1, mem_wdata = merge register.
  - The owner's rdata register gets the merged word. Go to RESP.
- **RESP**
  - Owner's ack = 1 for exactly this cycle. Go to IDLE.
- **After ack**
  - The requester drops req in the cycle after ack.
  - req still high in the next IDLE is taken as a new request.
- **Write rdata**
  - For a write, the rdata reported is the final word stored (full-word write: the latched wdata).
- mem_addr and mem_wdata are registered, driven from latched values; mem_we is decoded from the state.
- **Reset**
  - While rst_n = 0, mem_we is forced to 0 combinationally, so no write commits in any reset cycle.
  - State → IDLE; starve_cnt, acks, rdata registers, mem_addr and mem_wdata → 0; busy → 0.
  - Reset during ACCESS or WRITE of a partial store leaves the memory word unchanged and issues no ack.

## Timing
- Edge E0: req sampled in IDLE.
- ACCESS occupies E0..E1; RESP occupies E1..E2. ack is high during E1..E2.
- Read, full write and be == 0 write: 2 cycles req-to-ack.
- Partial write: ACCESS E0..E1, WRITE E1..E2, ack E2..E3; 3 cycles.
- The memory write commits on the falling edge within the ACCESS cycle (full write) or the WRITE cycle (partial write).
- Minimum spacing between grants: 3 cycles (read or full write), 4 cycles (partial write).
- ack never coincides for m0 and m1.
- Requests arriving while busy wait; nothing is queued beyond the req level.

## Structure
- Package dmem_arb_pkg: state encoding (IDLE/ACCESS/WRITE/RESP), owner constants OWN_M0/OWN_M1, default ADDR_W/DATA_W.
- Sub-module dmem_be_merge: combinational byte merge, inputs (old, new, be), output merged word. Reused by later load/store units.
- Arbiter, FSM and starvation counter stay in the top module.

## Test plan
- Reset, then m0 full write addr 0x005, data 0xDEADBEEF, be 0xF, followed by an m0 read of 0x005 → read ack exactly 2 cycles after req sampled, m0_rdata = 0xDEADBEEF, mem_we high for exactly one cycle across the two transactions.
- Preload 0x010 = 0x11223344; m1 write be 0x2, data 0x0000AA00 → ack at 3 cycles, memory = 0x1122AA44, m1_rdata = 0x1122AA44.
- m0 and m1 both request continuously, STARVE_LIMIT = 4 → grant order m0,m0,m0,m0,m1,m0,… ; m1 never waits more than 5 grants.
- Write with be 0x0 to 0x020 holding 0x12345678 → no mem_we pulse, ack at 2 cycles, rdata = 0x12345678.
- Reset pulsed during the WRITE cycle of a partial store to 0x030 → memory word unchanged, no ack, all outputs 0, next request served normally.
- Requester keeps req high after ack with a new address → second access granted from IDLE; exactly one ack per access.
